// File: rtl/spi_rom_reader.sv
// spi_rom_reader: runs one SPI flash READ (CS, command, 24-bit address, N data bytes) and
// streams received bytes out with a one-cycle valid. Macro SPI_FAST_READ_EN selects 0x0B + dummy byte.
module spi_rom_reader #(
  parameter int unsigned LEN_W    = 8,
  parameter logic [7:0]  READ_CMD = 8'h03
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [23:0]      addr,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             busy,
  output logic [7:0]       data,
  output logic             data_valid,
  output logic             done,
  output logic             spi_cs,
  output logic             spi_sclk,
  output logic             spi_mosi,
  input  logic             spi_miso
);

`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] L_CMD = 8'h0B;
`else
  localparam logic [7:0] L_CMD = READ_CMD;
`endif

  localparam logic [LEN_W:0] L_ZERO = {(LEN_W+1){1'b0}};
  localparam logic [LEN_W:0] L_ONE  = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [LEN_W:0] L_FULL = {1'b1, {LEN_W{1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
`ifdef SPI_FAST_READ_EN
    ST_DUMMY = 3'd3,
`endif
    ST_DATA  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [4:0]       r_bit_cnt;
  logic [4:0]       w_bit_cnt_nxt;
  logic [LEN_W:0]   r_byte_cnt;
  logic [LEN_W:0]   w_byte_cnt_nxt;
  logic [31:0]      r_tx;
  logic [31:0]      w_tx_nxt;
  logic             r_mosi;
  logic             w_mosi_nxt;
  logic [6:0]       r_shift;
  logic [6:0]       w_shift_nxt;
  logic [7:0]       w_shift_in;
  logic             r_miso_q;
  logic [7:0]       r_data;
  logic [7:0]       w_data_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_cs;
  logic             w_busy_nxt;

  assign busy       = r_cs;
  assign spi_cs     = r_cs;
  assign spi_mosi   = r_mosi;
  assign data       = r_data;
  assign data_valid = r_valid;
  assign done       = r_done;
  assign spi_sclk   = ~clk;

  // Next-state and datapath decode; abort takes priority over phase progress once busy.
  always_comb begin
    w_state_nxt    = r_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_byte_cnt_nxt = r_byte_cnt;
    w_tx_nxt       = r_tx;
    w_mosi_nxt     = 1'b0;
    w_shift_in     = {r_shift, r_miso_q};
    w_shift_nxt    = r_shift;
    w_data_nxt     = r_data;
    w_valid_nxt    = 1'b0;
    w_done_nxt     = 1'b0;
    if (r_state == ST_IDLE) begin
      if (start) begin
        w_state_nxt    = ST_CMD;
        w_bit_cnt_nxt  = 5'd0;
        w_byte_cnt_nxt = (len == {LEN_W{1'b0}}) ? L_FULL : {1'b0, len};
        w_tx_nxt       = {L_CMD[6:0], addr, 1'b0};
        w_mosi_nxt     = L_CMD[7];
        w_shift_nxt    = 7'd0;
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end else if (abort) begin
      w_state_nxt    = ST_IDLE;
      w_bit_cnt_nxt  = 5'd0;
      w_byte_cnt_nxt = L_ZERO;
    end else begin
      case (r_state)
        ST_CMD: begin
          w_mosi_nxt = r_tx[31];
          w_tx_nxt   = {r_tx[30:0], 1'b0};
          if (r_bit_cnt == 5'd7) begin
            w_state_nxt   = ST_ADDR;
            w_bit_cnt_nxt = 5'd0;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 5'd1;
          end
        end
        ST_ADDR: begin
          if (r_bit_cnt == 5'd23) begin
            w_bit_cnt_nxt = 5'd0;
`ifdef SPI_FAST_READ_EN
            w_state_nxt   = ST_DUMMY;
`else
            w_state_nxt   = ST_DATA;
`endif
          end else begin
            w_mosi_nxt    = r_tx[31];
            w_tx_nxt      = {r_tx[30:0], 1'b0};
            w_bit_cnt_nxt = r_bit_cnt + 5'd1;
          end
        end
`ifdef SPI_FAST_READ_EN
        ST_DUMMY: begin
          if (r_bit_cnt == 5'd7) begin
            w_state_nxt   = ST_DATA;
            w_bit_cnt_nxt = 5'd0;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 5'd1;
          end
        end
`endif
        // miso_q holds the bit sampled on the preceding SCLK rise
        ST_DATA: begin
          w_shift_nxt = w_shift_in[6:0];
          if (r_bit_cnt == 5'd7) begin
            w_bit_cnt_nxt  = 5'd0;
            w_data_nxt     = w_shift_in;
            w_valid_nxt    = 1'b1;
            w_byte_cnt_nxt = r_byte_cnt - L_ONE;
            if (r_byte_cnt == L_ONE) begin
              w_state_nxt = ST_IDLE;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = ST_DATA;
            end
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 5'd1;
          end
        end
        default: begin
          w_state_nxt    = ST_IDLE;
          w_bit_cnt_nxt  = 5'd0;
          w_byte_cnt_nxt = L_ZERO;
        end
      endcase
    end
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counters, shifters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_cnt  <= 5'd0;
      r_byte_cnt <= L_ZERO;
      r_tx       <= 32'd0;
      r_mosi     <= 1'b0;
      r_shift    <= 7'd0;
      r_data     <= 8'h00;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_cs       <= 1'b0;
    end else begin
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_tx       <= w_tx_nxt;
      r_mosi     <= w_mosi_nxt;
      r_shift    <= w_shift_nxt;
      r_data     <= w_data_nxt;
      r_valid    <= w_valid_nxt;
      r_done     <= w_done_nxt;
      r_cs       <= w_busy_nxt;
    end
  end

  // MISO is sampled on the SCLK rising edge, i.e. the clk falling edge.
  always_ff @(negedge clk) begin
    if (reset) begin
      r_miso_q <= 1'b0;
    end else begin
      r_miso_q <= spi_miso;
    end
  end

endmodule

// File: tb/tb_spi_rom_reader.sv
// tb_spi_rom_reader: random and directed stimulus against a transaction-timeline model of the
// reader plus a small flash model; outputs are compared on every cycle.
`timescale 1ns/1ps
module tb_spi_rom_reader;
  localparam int LEN_W = 8;
`ifdef SPI_FAST_READ_EN
  localparam int         D   = 8;
  localparam logic [7:0] CMD = 8'h0B;
`else
  localparam int         D   = 0;
  localparam logic [7:0] CMD = 8'h03;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        spi_miso = 1'b0;
  logic [23:0] addr = 24'd0;
  logic [7:0]  len = 8'd0;
  logic        busy, data_valid, done, spi_cs, spi_sclk, spi_mosi;
  logic [7:0]  data;

  spi_rom_reader #(.LEN_W(LEN_W), .READ_CMD(8'h03)) dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .len(len), .abort(abort),
    .busy(busy), .data(data), .data_valid(data_valid), .done(done), .spi_cs(spi_cs),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #20 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Flash contents: two pinned bytes, otherwise a fixed scramble of the address.
  function automatic logic [7:0] rom(input logic [23:0] a);
    if (a == 24'h000120) return 8'hA5;
    if (a == 24'h000121) return 8'h3C;
    return (a[7:0] * 8'd7) ^ a[15:8] ^ {a[19:16], a[23:20]} ^ 8'h5A;
  endfunction

  // Transaction timeline model: m_rel is the 1-based cycle number within the active transaction.
  bit          m_init = 0, m_act = 0;
  int          m_rel = 0, m_n = 0, m_L = 0;
  logic [23:0] m_addr = 24'd0;
  logic [7:0]  e_data = 8'h00;
  bit          e_valid = 0, e_done = 0;
  int          mk, mi;
  logic [7:0]  mbyte;

  always @(posedge clk) begin
    e_valid = 0;
    e_done  = 0;
    if (reset) begin
      m_init = 1; m_act = 0; m_rel = 0; e_data = 8'h00;
    end else if (m_act) begin
      if (abort) begin
        m_act = 0;
      end else begin
        if (m_rel >= 33 + D && (m_rel - 33 - D) % 8 == 7) begin
          mk = (m_rel - 33 - D) / 8;
          e_valid = 1;
          e_data  = rom(m_addr + 24'(mk));
          e_done  = (mk == m_n - 1);
        end
        if (m_rel == m_L) m_act = 0;
        else m_rel++;
      end
    end else if (start) begin
      m_act = 1; m_rel = 1; m_addr = addr;
      m_n = (len == 8'd0) ? 256 : int'(len);
      m_L = 32 + D + 8 * m_n;
    end
    if (m_act && m_rel >= 33 + D) begin
      mi = m_rel - 33 - D;
      mbyte = rom(m_addr + 24'(mi / 8));
      spi_miso = mbyte[7 - (mi % 8)];
    end else begin
      spi_miso = 1'($urandom);
    end
  end

  // Monitor state for the literal checks.
  bit          prev_cs = 0;
  int          t_rel = 0, cs_run = 0, low_run = 0, last_cs_len = 0, last_gap = 0;
  int          n_valid = 0, n_done = 0, done_rel = 0;
  logic [7:0]  q_data[$];
  int          q_rel[$];
  logic [31:0] mosi_word = 32'd0;
  logic [31:0] e_word;

  always @(negedge clk) begin
    #1;
    if (m_init) begin
      e_word = {CMD, m_addr};
      chk("spi_cs", spi_cs, m_act);
      chk("busy", busy, m_act);
      chk("spi_mosi", spi_mosi, (m_act && m_rel <= 32) ? e_word[32 - m_rel] : 1'b0);
      chk("data_valid", data_valid, e_valid);
      chk("done", done, e_done);
      chk("data", data, e_data);
      chk("spi_sclk", spi_sclk, 1'b1);
      if (spi_cs && !prev_cs) begin t_rel = 1; last_gap = low_run; low_run = 0; end
      else t_rel++;
      if (!spi_cs && prev_cs) begin last_cs_len = cs_run; cs_run = 0; end
      if (spi_cs) cs_run++; else low_run++;
      if (spi_cs && t_rel <= 32) mosi_word = {mosi_word[30:0], spi_mosi};
      if (data_valid) begin n_valid++; q_data.push_back(data); q_rel.push_back(t_rel); end
      if (done) begin n_done++; done_rel = t_rel; end
      prev_cs = spi_cs;
    end
  end

  task automatic clear_mon();
    n_valid = 0; n_done = 0; done_rel = 0;
    q_data.delete(); q_rel.delete();
  endtask

  task automatic go(input logic [23:0] a, input logic [7:0] l, input bit with_abort);
    start = 1'b1; addr = a; len = l; abort = with_abort;
    @(negedge clk);
    start = 1'b0; abort = 1'b0; addr = 24'($urandom); len = 8'($urandom);
  endtask

  task automatic wait_idle(input int bound);
    for (int c = 0; c < bound && m_act; c++) @(negedge clk);
    if (m_act) chk("wait_idle_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  task automatic wait_rel(input int r);
    for (int c = 0; c < 4000 && !(m_act && m_rel == r); c++) @(negedge clk);
    if (!(m_act && m_rel == r)) chk("wait_rel_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int bad;
    int r;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_cs", spi_cs, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_data", data, 8'h00);

    // Directed read of two pinned bytes.
    clear_mon();
    go(24'h000120, 8'd2, 1'b0);
    wait_idle(200);
    chk("t1_cs_len", last_cs_len, 48 + D);
    chk("t1_mosi", mosi_word, {CMD, 24'h000120});
    chk("t1_nvalid", n_valid, 2);
    if (n_valid == 2) begin
      chk("t1_byte0", q_data[0], 8'hA5);
      chk("t1_rel0", q_rel[0], 41 + D);
      chk("t1_byte1", q_data[1], 8'h3C);
      chk("t1_rel1", q_rel[1], 49 + D);
    end
    chk("t1_ndone", n_done, 1);
    chk("t1_done_rel", done_rel, 49 + D);

    // Single byte from address 0.
    clear_mon();
    go(24'h000000, 8'd1, 1'b0);
    wait_idle(200);
    chk("t1b_cs_len", last_cs_len, 40 + D);
    chk("t1b_mosi", mosi_word, {CMD, 24'h000000});
    chk("t1b_done_rel", done_rel, 41 + D);

    // len = 0 means 256 bytes.
    clear_mon();
    go(24'($urandom), 8'd0, 1'b0);
    wait_idle(3000);
    chk("t2_nvalid", n_valid, 256);
    chk("t2_ndone", n_done, 1);
    chk("t2_cs_len", last_cs_len, 2080 + D);
    bad = 0;
    foreach (q_rel[k]) if (q_rel[k] != 41 + D + 8 * k) bad++;
    chk("t2_spacing", bad, 0);

    // start during ADDR is ignored; start with done chains with one idle cycle.
    clear_mon();
    go(24'h00ABCD, 8'd3, 1'b0);
    wait_rel(15);
    go(24'hFFFFFE, 8'd5, 1'b0);
    for (int c = 0; c < 400 && !e_done; c++) @(negedge clk);
    go(24'hFFFFFF, 8'd2, 1'b0);
    wait_idle(400);
    chk("t3_gap", last_gap, 1);
    chk("t3_nvalid", n_valid, 5);
    chk("t3_ndone", n_done, 2);

    // abort in the 3rd bit of byte 1.
    clear_mon();
    go(24'h012345, 8'd4, 1'b0);
    wait_rel(43 + D);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t4_cs", spi_cs, 1'b0);
    chk("t4_busy", busy, 1'b0);
    repeat (40) @(negedge clk);
    chk("t4_nvalid", n_valid, 1);
    chk("t4_ndone", n_done, 0);

    // reset during CMD, then a clean transaction.
    go(24'h000200, 8'd2, 1'b0);
    wait_rel(4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t5_cs", spi_cs, 1'b0);
    chk("t5_data", data, 8'h00);
    chk("t5_valid", data_valid, 1'b0);
    clear_mon();
    go(24'h000300, 8'd3, 1'b0);
    wait_idle(300);
    chk("t5_nvalid", n_valid, 3);
    chk("t5_ndone", n_done, 1);

    // Randomized transactions with stray starts, aborts and start+abort in IDLE.
    for (int it = 0; it < 20; it++) begin
      go(24'($urandom), 8'($urandom_range(1, 5)), $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) begin
        r = $urandom_range(2, m_L);
        wait_rel(r);
        start = 1'b1; addr = 24'($urandom); len = 8'($urandom);
        @(negedge clk);
        start = 1'b0;
      end
      if ($urandom_range(0, 3) == 0 && m_act) begin
        r = $urandom_range(m_rel + 1, m_L);
        wait_rel(r);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
      end
      if ($urandom_range(0, 1) == 0) begin
        for (int c = 0; c < 400 && m_act; c++) @(negedge clk);
      end else begin
        wait_idle(400);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    wait_idle(400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/spi_rom_reader.md
# spi_rom_reader

Sequential SPI flash read engine for the VGA/SPI-ROM design. It accepts a start request carrying a 24-bit address and a byte count, then drives one complete READ transaction: chip select, command, address, and data phases. Received bytes come out as a one-cycle-valid byte stream that a line buffer or pixel stage consumes. It sits between the ROM pins and the display logic, in place of free-running, hpos-slaved SPI sequencing.

## Interface
- `LEN_W`, default 8: width of the byte-count input; count 0 means 2^LEN_W bytes.
- `READ_CMD`, default 8'h03: command byte sent in normal mode.

Ports:
- `clk`  in  1  system clock (25.175 MHz pixel clock).
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a transaction; sampled only in IDLE.
- `addr`  in  24  start byte address; captured with `start`.
- `len`  in  LEN_W  bytes to read; captured with `start`.
- `abort`  in  1  terminate the current transaction.
- `busy`  out  1  high whenever the FSM is not IDLE.
- `data`  out  8  received byte, MSB first on the wire.
- `data_valid`  out  1  one-cycle pulse per byte.
- `done`  out  1  one-cycle pulse with the final byte's `data_valid`.
- `spi_cs`  out  1  chip select, active HIGH (inverted at the pad).
- `spi_sclk`  out  1  equal to `~clk`, continuous.
- `spi_mosi`  out  1  command/address bits.
- `spi_miso`  in  1  flash data.

## Operation
- FSM states: IDLE → CMD (8 cycles) → ADDR (24 cycles) → [DUMMY (8 cycles), only with the macro] → DATA (8×N cycles) → IDLE.
- A 5-bit bit counter times each phase. A byte counter of width LEN_W+1 is loaded with N = (`len`==0 ? 2^LEN_W : `len`).
- IDLE: `spi_cs`=0, `spi_mosi`=0. When `start`=1, capture `addr`/`len` and go to CMD.
- CMD/ADDR: `spi_mosi` presents the command, then `addr[23:0]`, MSB first. Each bit changes at the `clk` posedge, which is the SCLK falling edge.
- DUMMY and DATA: `spi_mosi`=0.
- DATA: `spi_miso` is captured at the `clk` negedge (SCLK rising) into `miso_q`. `miso_q` shifts into an 8-bit register at the next posedge.
- After the 8th bit of each byte, `data` is updated and `data_valid`=1 for one cycle. `data` holds its value until the next byte.
- Final byte: `done`=1 in the same cycle as its `data_valid`. The FSM is in IDLE that cycle, with `spi_cs`=0 and `busy`=0.
- `start` while busy: ignored, with no queuing.
- `start` in the same cycle as `done`: accepted, because the FSM is IDLE. `spi_cs` is then low for exactly one cycle between transactions.
- `abort` while busy: go to IDLE next edge, with `spi_cs`=0. No further `data_valid`. No `done`. A partial byte is discarded.
- `abort` in IDLE: no effect. `abort` and `start` together in IDLE: `start` wins.
- `reset` (any state): next edge forces IDLE. Reset values: `spi_cs`=0, `spi_mosi`=0, `busy`=0, `data_valid`=0, `done`=0, `data`=8'h00, all counters 0.

## Timing
- Edge 0 samples `start`.
- CMD occupies cycles 1–8; `spi_cs` rises after edge 0.
- ADDR occupies cycles 9–32.
- DATA begins at cycle 33. In fast mode, DUMMY is cycles 33–40 and DATA begins at cycle 41.
- Byte k (0-based) has `data_valid` high in cycle 41+8k (normal mode) or 49+8k (fast mode).
- `spi_cs` is high for 32+8N cycles (normal) or 40+8N cycles (fast).
- Byte rate: one byte per 8 cycles, with no gaps.
- `spi_mosi` must be stable across each SCLK rising edge, i.e. mid-cycle.

## Configuration
- `SPI_FAST_READ_EN` defined:
  - The command is 8'h0B, replacing `READ_CMD`.
  - The DUMMY state (8 cycles, MOSI=0) is inserted between ADDR and DATA.
  - All DATA-phase timings shift by +8 cycles.
- `SPI_FAST_READ_EN` undefined:
  - The command is `READ_CMD`.
  - The DUMMY state does not exist, and its logic is not synthesized.

## Test plan
- Normal read, `addr`=24'h000120, `len`=2, flash model returns A5,3C:
  - MOSI carries 03,00,01,20 over cycles 1–32.
  - `data_valid` is high at cycles 41 (data=A5) and 49 (data=3C).
  - `done` is high at cycle 49.
  - `spi_cs` is high for exactly 48 cycles.
- `len`=0 with LEN_W=8:
  - 256 `data_valid` pulses at an 8-cycle spacing, matching the model pattern.
  - `done` is high only on the 256th.
  - `spi_cs` is high for 2080 cycles.
- `start` pulsed during ADDR:
  - Ignored; `addr` is not recaptured.
  - A new `start` coincident with `done` gives exactly one low `spi_cs` cycle, then a new CMD.
- `abort` mid-DATA, in the 3rd bit of byte 1:
  - `spi_cs`=0 and `busy`=0 next cycle.
  - No further `data_valid`; no `done`.
- `reset` during CMD:
  - All outputs at their reset values on the next cycle.
  - A subsequent `start` produces a clean full transaction.
- With `SPI_FAST_READ_EN`, `addr`=0, `len`=1:
  - MOSI carries 0B then 24 zeros, then 8 dummy zeros.
  - `data_valid` and `done` at cycle 49.
  - `spi_cs` is high for 48 cycles.
